wb_boot_loader: RTL and testbench
=================================

Name: wb_boot_loader

Overview:
Synthesizable Wishbone boot preloader that replaces testbench-only backdoor memory loading. It accepts program words on a valid/ready stream (bench model, flash reader or debug link) and writes them sequentially into system RAM as a classic Wishbone master. It holds the CPU core in reset until the image is loaded, then releases it after a programmable delay. It sits between the clock/reset source and the core reset input in vscale-class SoC tops.

Parameters:
DW, 32, Wishbone/stream data width (multiple of 8)
AW, 32, Wishbone address width
BASE_ADDR, 0, byte address of first word written
NUM_WORDS, 1024, words in boot image; 0 is legal
RELEASE_DELAY, 16, cycles between last write ack and core reset release; 0 is legal
MAX_RETRIES, 3, re-issues allowed per word after wbm_err_i

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
s_data_i  in  DW  boot word
s_valid_i  in  1  boot word valid
s_ready_o  out  1  loader ready for a word
wbm_adr_o  out  AW  byte address
wbm_dat_o  out  DW  write data
wbm_sel_o  out  DW/8  byte selects, always all ones
wbm_we_o  out  1  write enable
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  always 3'b000 (classic)
wbm_bte_o  out  2  always 2'b00
wbm_dat_i  in  DW  read data (used only with readback)
wbm_ack_i  in  1  ack
wbm_err_i  in  1  bus error
core_rst_o  out  1  active-high core reset
done_o  out  1  image loaded, core running
error_o  out  1  fatal load error
word_cnt_o  out  CW  words committed, CW = $clog2(NUM_WORDS+1)

Behaviour:
- Reset (async assert, sync release): state IDLE, core_rst_o=1, wbm_adr_o=BASE_ADDR, all other outputs 0, retry counter 0. Asserting reset mid-transfer drops cyc/stb immediately.
- States: IDLE, WAIT_DATA, WRITE, READ, CHECK, DELAY, RUN, ERROR.
- IDLE: one cycle. Moves to WAIT_DATA, or to DELAY if NUM_WORDS==0.
- WAIT_DATA: s_ready_o=1. On s_valid_i&s_ready_o, latch s_data_i into wbm_dat_o and go to WRITE next cycle. s_ready_o is 0 in every other state.
- WRITE: cyc=stb=we=1 and are held until ack or err.
  - ack (and not err): word_cnt_o+1, wbm_adr_o+DW/8, retry counter cleared, cyc/stb drop next cycle. Next state is DELAY if the count reaches NUM_WORDS, else WAIT_DATA.
  - err, including err and ack in the same cycle: err wins. If retries<MAX_RETRIES, increment retries, drop stb for exactly one cycle, then re-issue the same address/data. Otherwise go to ERROR.
- DELAY: counts RELEASE_DELAY cycles, then RUN. With RELEASE_DELAY=0, RUN is entered the cycle after the final ack (or after IDLE when NUM_WORDS==0).
- RUN: core_rst_o=0, done_o=1. Terminal until reset; the bus is idle.
- ERROR: core_rst_o=1, error_o=1, bus idle. Terminal until reset.
- The address counter is AW bits and wraps silently modulo 2^AW.
- word_cnt_o saturates at NUM_WORDS.
- At most one outstanding bus cycle at any time.

Optional Feature:
BOOT_LOADER_READBACK_EN
- When defined: after each write ack, enter READ, issuing a read (we=0) to the same address. On ack, CHECK compares wbm_dat_i with the latched word.
  - Match: count/advance as above.
  - Mismatch: go directly to ERROR (no retry).
  - err during READ: follows the same retry rules, re-issuing the read.
- When undefined: READ and CHECK are not synthesized, and wbm_dat_i is unused.

Test Plan:
- NUM_WORDS=4, BASE_ADDR=0x100, RELEASE_DELAY=2, stream 0xA0..0xA3 with zero-wait ack. Expect:
  - writes to 0x100, 0x104, 0x108, 0x10C with matching data;
  - core_rst_o falls and done_o rises exactly 3 cycles after the 4th ack;
  - word_cnt_o=4.
- Stream with s_valid_i gaps and ack delayed 3 cycles. Expect:
  - s_ready_o low outside WAIT_DATA;
  - cyc/stb held until ack;
  - no word dropped or duplicated.
- err on word 1 twice, then ack (MAX_RETRIES=3). Expect stb low for one cycle between attempts, the same address/data, then normal completion. With err four times: error_o=1, core_rst_o stays 1.
- NUM_WORDS=0, RELEASE_DELAY=0. Expect done_o=1 and core_rst_o=0 two cycles after reset release, with no bus activity.
- Assert wb_rst_ni low mid-WRITE. Expect cyc/stb/done_o=0 and core_rst_o=1 asynchronously; after release, reloading starts at BASE_ADDR with word_cnt_o=0.
- With BOOT_LOADER_READBACK_EN, slave returns 0xDEAD on readback of word 2. Expect error_o=1, word_cnt_o=2, core_rst_o held at 1.

Source files
------------

// File: rtl/wb_boot_loader.sv
// Wishbone boot preloader: streams an image into RAM and holds the core in reset until it is loaded.
// Optional macro BOOT_LOADER_READBACK_EN reads each written word back and compares it before committing.
module wb_boot_loader #(
  parameter int            DW            = 32,
  parameter int            AW            = 32,
  parameter logic [AW-1:0] BASE_ADDR     = '0,
  parameter int            NUM_WORDS     = 1024,
  parameter int            RELEASE_DELAY = 16,
  parameter int            MAX_RETRIES   = 3,
  localparam int           CW            = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            core_rst_o,
  output logic            done_o,
  output logic            error_o,
  output logic [CW-1:0]   word_cnt_o
);

  localparam int DLW = (RELEASE_DELAY > 0) ? $clog2(RELEASE_DELAY + 1) : 1;
  localparam int RW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, WRITE, READ, CHECK, DELAY, RUN, ERROR
  } state_e;

  state_e         state_q;
  logic [AW-1:0]  adr_q;
  logic [DW-1:0]  dat_q;
  logic           cyc_q, stb_q, we_q, ready_q;
  logic           coreRst_q, done_q, error_q;
  logic [CW-1:0]  wordCnt_q;
  logic [RW-1:0]  retry_q;
  logic [DLW-1:0] delay_q;

  logic [AW-1:0]  adr_d;
  logic [CW-1:0]  wordCnt_d;
  logic           lastWord_d;
  logic           retryOk_d;

  assign adr_d      = adr_q + AW'(DW / 8);
  assign wordCnt_d  = (wordCnt_q == CW'(NUM_WORDS)) ? wordCnt_q : wordCnt_q + 1'b1;
  assign lastWord_d = (wordCnt_d == CW'(NUM_WORDS));
  assign retryOk_d  = (retry_q < RW'(MAX_RETRIES));

`ifdef BOOT_LOADER_READBACK_EN
  logic [DW-1:0] rdData_q;
`else
  logic unusedRdData;
  assign unusedRdData = ^wbm_dat_i;
`endif

  // One registered FSM; a low strobe while in WRITE/READ marks the idle cycle before (re)issuing.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      adr_q     <= BASE_ADDR;
      dat_q     <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      coreRst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wordCnt_q <= '0;
      retry_q   <= '0;
      delay_q   <= '0;
`ifdef BOOT_LOADER_READBACK_EN
      rdData_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (NUM_WORDS == 0) begin
            state_q <= DELAY;
          end else begin
            state_q <= WAIT_DATA;
            ready_q <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (s_valid_i) begin
            dat_q   <= s_data_i;
            ready_q <= 1'b0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!stb_q) begin
            stb_q <= 1'b1;
          end else if (wbm_err_i) begin
            if (retryOk_d) begin
              retry_q <= retry_q + 1'b1;
              stb_q   <= 1'b0;
            end else begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              we_q    <= 1'b0;
              error_q <= 1'b1;
              state_q <= ERROR;
            end
          end else if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            retry_q <= '0;
`ifdef BOOT_LOADER_READBACK_EN
            state_q <= READ;
`else
            wordCnt_q <= wordCnt_d;
            adr_q     <= adr_d;
            if (lastWord_d) begin
              state_q <= DELAY;
            end else begin
              state_q <= WAIT_DATA;
              ready_q <= 1'b1;
            end
`endif
          end
        end
`ifdef BOOT_LOADER_READBACK_EN
        READ: begin
          if (!stb_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
          end else if (wbm_err_i) begin
            if (retryOk_d) begin
              retry_q <= retry_q + 1'b1;
              stb_q   <= 1'b0;
            end else begin
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              error_q <= 1'b1;
              state_q <= ERROR;
            end
          end else if (wbm_ack_i) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            retry_q  <= '0;
            rdData_q <= wbm_dat_i;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (rdData_q == dat_q) begin
            wordCnt_q <= wordCnt_d;
            adr_q     <= adr_d;
            if (lastWord_d) begin
              state_q <= DELAY;
            end else begin
              state_q <= WAIT_DATA;
              ready_q <= 1'b1;
            end
          end else begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end
        end
`endif
        DELAY: begin
          if (delay_q == DLW'(RELEASE_DELAY)) begin
            coreRst_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RUN;
          end else begin
            delay_q <= delay_q + 1'b1;
          end
        end
        RUN, ERROR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready_o  = ready_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = '1;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_cti_o  = 3'b000;
  assign wbm_bte_o  = 2'b00;
  assign core_rst_o = coreRst_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign word_cnt_o = wordCnt_q;

endmodule

// File: tb/tb_wb_boot_loader.sv
// Scoreboard bench for wb_boot_loader: expected writes are queued by the stimulus and
// popped by an independent bus monitor; a second instance covers the empty-image case.
module tb_wb_boot_loader;

  localparam int CW = 3;
`ifdef BOOT_LOADER_READBACK_EN
  localparam int ACK_TO_RUN = 4;
`else
  localparam int ACK_TO_RUN = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [31:0] sData;
  logic        sValid;
  logic        sReady;
  logic [31:0] adr, datO;
  logic [31:0] datI = '0;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0;
  logic        coreRst, done, errorO;
  logic [CW-1:0] wordCnt;

  logic        sReady0, we0, cyc0, stb0, coreRst0, done0, error0;
  logic [31:0] adr0, datO0;
  logic [3:0]  sel0;
  logic [2:0]  cti0;
  logic [1:0]  bte0;
  logic [0:0]  wordCnt0;

  wb_boot_loader #(
    .DW(32), .AW(32), .BASE_ADDR(32'h100), .NUM_WORDS(4), .RELEASE_DELAY(2), .MAX_RETRIES(3)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rstN),
    .s_data_i(sData), .s_valid_i(sValid), .s_ready_o(sReady),
    .wbm_adr_o(adr), .wbm_dat_o(datO), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_dat_i(datI), .wbm_ack_i(ack), .wbm_err_i(err),
    .core_rst_o(coreRst), .done_o(done), .error_o(errorO), .word_cnt_o(wordCnt)
  );

  wb_boot_loader #(
    .DW(32), .AW(32), .BASE_ADDR(32'h0), .NUM_WORDS(0), .RELEASE_DELAY(0), .MAX_RETRIES(3)
  ) dutZero (
    .wb_clk_i(clk), .wb_rst_ni(rstN),
    .s_data_i(32'h0), .s_valid_i(1'b0), .s_ready_o(sReady0),
    .wbm_adr_o(adr0), .wbm_dat_o(datO0), .wbm_sel_o(sel0), .wbm_we_o(we0),
    .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_cti_o(cti0), .wbm_bte_o(bte0),
    .wbm_dat_i(32'h0), .wbm_ack_i(1'b0), .wbm_err_i(1'b0),
    .core_rst_o(coreRst0), .done_o(done0), .error_o(error0), .word_cnt_o(wordCnt0)
  );

  int assertCnt = 0;
  int failCnt   = 0;
  int cycleCnt  = 0;
  logic [63:0] expQ[$];

  // Slave model configuration
  int          ackDelay  = 0;
  int          waitCnt   = 0;
  int          errsLeft  = 0;
  logic [31:0] errAddr   = '0;
  logic        badEn     = 1'b0;
  logic [31:0] badAddr   = '0;
  logic [31:0] mem [logic [31:0]];

  // Monitor state
  logic        prevPend    = 1'b0;
  logic [31:0] prevAdr     = '0;
  int          gapState    = 0;
  logic [31:0] gapAdr      = '0;
  logic [31:0] gapDat      = '0;
  int          errSeen     = 0;
  int          lastAckEdge = 0;
  int          fallEdge    = 0;
  logic        prevCoreRst = 1'b1;
  logic        zeroBusSeen = 1'b0;
  logic [63:0] popped;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave answers at the falling edge so the master samples a stable ack/err on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      ack = 1'b0;
      err = 1'b0;
      if (cyc && stb) begin
        if (waitCnt >= ackDelay) begin
          waitCnt = 0;
          if (errsLeft > 0 && adr == errAddr) begin
            err = 1'b1;
            errsLeft--;
          end else begin
            ack = 1'b1;
            if (we) mem[adr] = datO;
            else if (badEn && adr == badAddr) datI = 32'hDEAD;
            else datI = mem.exists(adr) ? mem[adr] : 32'h0;
          end
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Bus monitor: pops the scoreboard on each accepted write and checks bus-protocol invariants.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rstN) begin
        prevPend    = 1'b0;
        gapState    = 0;
        prevCoreRst = 1'b1;
      end else begin
        if (cyc) checkOutput("readyOutsideWait", {63'h0, sReady}, 64'h0);
        if (prevPend) begin
          checkOutput("cycStbHeld", {62'h0, cyc, stb}, 64'h3);
          checkOutput("adrHeld", {32'h0, adr}, {32'h0, prevAdr});
        end
        prevPend = cyc && stb && !ack && !err;
        prevAdr  = adr;
        if (gapState == 1) begin
          if (!errorO) begin
            checkOutput("retryGapStb", {63'h0, stb}, 64'h0);
            gapState = 2;
          end else begin
            gapState = 0;
          end
        end else if (gapState == 2) begin
          checkOutput("retryStb", {63'h0, stb}, 64'h1);
          checkOutput("retryAdr", {32'h0, adr}, {32'h0, gapAdr});
          checkOutput("retryDat", {32'h0, datO}, {32'h0, gapDat});
          gapState = 0;
        end
        if (cyc && stb && err) begin
          gapState = 1;
          gapAdr   = adr;
          gapDat   = datO;
          errSeen++;
        end
        if (cyc && stb && ack && !err) begin
          lastAckEdge = cycleCnt + 1;
          if (we) begin
            if (expQ.size() == 0) begin
              assertCnt++;
              failCnt++;
              $display("[TB] FAIL unexpectedWrite: got adr 0x%0h dat 0x%0h, expected no write", adr, datO);
            end else begin
              popped = expQ.pop_front();
              checkOutput("writeAdr", {32'h0, adr}, {32'h0, popped[63:32]});
              checkOutput("writeDat", {32'h0, datO}, {32'h0, popped[31:0]});
            end
          end
        end
        if (prevCoreRst && !coreRst) fallEdge = cycleCnt;
        prevCoreRst = coreRst;
      end
      if (cyc0 || stb0 || sReady0) zeroBusSeen = 1'b1;
    end
  end

  task automatic resetDut();
    rstN     = 1'b0;
    sValid   = 1'b0;
    sData    = '0;
    ackDelay = 0;
    errsLeft = 0;
    badEn    = 1'b0;
    errSeen  = 0;
    expQ.delete();
    mem.delete();
    repeat (2) @(negedge clk);
    checkOutput("rstCoreRst", {63'h0, coreRst}, 64'h1);
    checkOutput("rstOutputs", {59'h0, done, errorO, cyc, stb, sReady}, 64'h0);
    checkOutput("rstAdr", {32'h0, adr}, 64'h100);
    checkOutput("rstWordCnt", {61'h0, wordCnt}, 64'h0);
    rstN = 1'b1;
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] d, input int gap, input bit expectIt);
    int n;
    repeat (gap) @(negedge clk);
    sData  = d;
    sValid = 1'b1;
    if (expectIt) expQ.push_back({32'h100 + 32'(4 * idx), d});
    n = 0;
    while (!sReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("handshake", {63'h0, sReady}, 64'h1);
    @(negedge clk);
    sValid = 1'b0;
  endtask

  task automatic waitFinal(input int maxCyc);
    int n;
    n = 0;
    while (!(done || errorO) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN   = 1'b0;
    sValid = 1'b0;
    sData  = '0;

    // Basic load plus the empty-image instance coming out of reset alongside it.
    resetDut();
    checkOutput("zeroRstCore", {63'h0, coreRst0}, 64'h1);
    @(negedge clk);
    checkOutput("zeroDoneEarly", {63'h0, done0}, 64'h0);
    @(negedge clk);
    checkOutput("zeroDone", {62'h0, done0, coreRst0}, 64'h2);
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'hA0 + 32'(i), 0, 1'b1);
    waitFinal(60);
    checkOutput("basicDone", {61'h0, done, coreRst, errorO}, 64'h4);
    checkOutput("basicWordCnt", {61'h0, wordCnt}, 64'h4);
    checkOutput("basicReleaseLatency", 64'(fallEdge - lastAckEdge), 64'(ACK_TO_RUN));
    checkOutput("basicQueueEmpty", 64'(expQ.size()), 64'h0);

    // Valid gaps and a slow slave.
    resetDut();
    ackDelay = 3;
    applyStimulus(0, 32'hB0, 2, 1'b1);
    applyStimulus(1, 32'hB1, 0, 1'b1);
    applyStimulus(2, 32'hB2, 3, 1'b1);
    applyStimulus(3, 32'hB3, 1, 1'b1);
    waitFinal(80);
    checkOutput("slowDone", {61'h0, done, coreRst, errorO}, 64'h4);
    checkOutput("slowWordCnt", {61'h0, wordCnt}, 64'h4);
    checkOutput("slowQueueEmpty", 64'(expQ.size()), 64'h0);

    // Two errors on word 1 are absorbed by retries.
    resetDut();
    errAddr  = 32'h104;
    errsLeft = 2;
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'hC0 + 32'(i), 0, 1'b1);
    waitFinal(80);
    checkOutput("retryDone", {61'h0, done, coreRst, errorO}, 64'h4);
    checkOutput("retryErrCount", 64'(errSeen), 64'h2);
    checkOutput("retryWordCnt", {61'h0, wordCnt}, 64'h4);
    checkOutput("retryQueueEmpty", 64'(expQ.size()), 64'h0);

    // Four errors on word 1 exhaust the retry budget.
    resetDut();
    errAddr  = 32'h104;
    errsLeft = 4;
    applyStimulus(0, 32'hD0, 0, 1'b1);
    applyStimulus(1, 32'hD1, 0, 1'b0);
    waitFinal(80);
    checkOutput("fatalFlags", {61'h0, done, coreRst, errorO}, 64'h3);
    checkOutput("fatalErrCount", 64'(errSeen), 64'h4);
    checkOutput("fatalWordCnt", {61'h0, wordCnt}, 64'h1);
    checkOutput("fatalBusIdle", {62'h0, cyc, sReady}, 64'h0);
    checkOutput("fatalQueueEmpty", 64'(expQ.size()), 64'h0);

    // Reset asserted in the middle of a stalled write.
    resetDut();
    ackDelay = 5;
    applyStimulus(0, 32'hE0, 0, 1'b1);
    checkOutput("midWriteCyc", {62'h0, cyc, stb}, 64'h3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstBus", {61'h0, cyc, stb, done}, 64'h0);
    checkOutput("asyncRstCore", {63'h0, coreRst}, 64'h1);
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'hF0 + 32'(i), 0, 1'b1);
    waitFinal(60);
    checkOutput("reloadDone", {61'h0, done, coreRst, errorO}, 64'h4);
    checkOutput("reloadWordCnt", {61'h0, wordCnt}, 64'h4);
    checkOutput("reloadQueueEmpty", 64'(expQ.size()), 64'h0);

`ifdef BOOT_LOADER_READBACK_EN
    // Readback of word 2 returns corrupted data.
    resetDut();
    badEn   = 1'b1;
    badAddr = 32'h108;
    for (int i = 0; i < 3; i++) applyStimulus(i, 32'h50 + 32'(i), 0, 1'b1);
    waitFinal(80);
    checkOutput("readbackFlags", {61'h0, done, coreRst, errorO}, 64'h3);
    checkOutput("readbackWordCnt", {61'h0, wordCnt}, 64'h2);
    checkOutput("readbackQueueEmpty", 64'(expQ.size()), 64'h0);
`endif

    checkOutput("zeroNoBusActivity", {63'h0, zeroBusSeen}, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
